// File: rtl/eth_tx_pkg.sv
// Shared constants and encodings for the Ethernet TX path: scheduler states,
// source select values and default packet/timing parameters.
package eth_tx_pkg;

    localparam int DEF_PAYLOAD_BYTES = 1360;
    localparam int DEF_IFG_CYCLES    = 24;
    localparam int DEF_TX_TIMEOUT    = 4096;

    localparam logic SRC_VID  = 1'b0;
    localparam logic SRC_STAT = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } tx_state_e;

endpackage

// File: rtl/eth_tx_rr_arb.sv
// Two-way round-robin arbiter choosing between the video and status sources.
// When both request, the source that did not go last wins.
module eth_tx_rr_arb
    import eth_tx_pkg::*;
(
    input  logic req_vid_i,
    input  logic req_stat_i,
    input  logic last_src_i,
    output logic grant_o,
    output logic valid_o
);

    always_comb begin
        valid_o = req_vid_i | req_stat_i;
        if (req_vid_i && req_stat_i) begin
            grant_o = ~last_src_i;
        end else if (req_stat_i) begin
            grant_o = SRC_STAT;
        end else begin
            grant_o = SRC_VID;
        end
    end

endmodule

// File: rtl/ethernet_tx_sched.sv
// Packet scheduler in front of ethernet_tx: picks a source, holds send enable
// for the packet, guards it with a timeout and enforces the inter-frame gap.
//
// state | meaning
// IDLE  | waiting for enable and a ready source
// SEND  | packet in flight, send enable held, timeout timer running
// GAP   | inter-frame gap, no new packet may start
module ethernet_tx_sched
    import eth_tx_pkg::*;
#(
    parameter int PAYLOAD_BYTES = DEF_PAYLOAD_BYTES,
    parameter int FIFO_CNT_W    = 12,
    parameter int IFG_CYCLES    = DEF_IFG_CYCLES,
    parameter int TX_TIMEOUT    = DEF_TX_TIMEOUT
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  enable_i,
    input  logic [FIFO_CNT_W-1:0] vid_fifo_cnt_i,
    input  logic                  stat_req_i,
    output logic                  stat_ack_o,
    input  logic                  tx_done_i,
    output logic                  tx_send_enable_o,
    output logic                  tx_src_sel_o,
    output logic                  busy_o,
    output logic [15:0]           vid_pkt_cnt_o,
    output logic                  err_timeout_o
);

    localparam int TMR_W = $clog2(TX_TIMEOUT);
    localparam int GAP_W = $clog2(IFG_CYCLES + 1);
    localparam logic [TMR_W-1:0]      TMR_LAST    = TMR_W'(TX_TIMEOUT - 1);
    localparam logic [GAP_W-1:0]      GAP_LAST    = GAP_W'(IFG_CYCLES - 1);
    localparam logic [FIFO_CNT_W-1:0] PAYLOAD_THR = FIFO_CNT_W'(PAYLOAD_BYTES);

    tx_state_e        state_q, state_d;
    logic             src_q, src_d;
    logic             last_src_q, last_src_d;
    logic [TMR_W-1:0] tx_tmr_q, tx_tmr_d;
    logic [GAP_W-1:0] gap_tmr_q, gap_tmr_d;
    logic [15:0]      vid_pkt_cnt_q, vid_pkt_cnt_d;
    logic             err_timeout_q, err_timeout_d;
    logic             stat_ack_q, stat_ack_d;
    logic             tx_send_enable_q, busy_q;

    logic vid_rdy;
    logic arb_grant;
    logic arb_valid;

    assign vid_rdy = (vid_fifo_cnt_i >= PAYLOAD_THR);

    eth_tx_rr_arb u_arb (
        .req_vid_i  (vid_rdy),
        .req_stat_i (stat_req_i),
        .last_src_i (last_src_q),
        .grant_o    (arb_grant),
        .valid_o    (arb_valid)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q          <= ST_IDLE;
            src_q            <= SRC_VID;
            last_src_q       <= SRC_STAT;
            tx_tmr_q         <= '0;
            gap_tmr_q        <= '0;
            vid_pkt_cnt_q    <= '0;
            err_timeout_q    <= 1'b0;
            stat_ack_q       <= 1'b0;
            tx_send_enable_q <= 1'b0;
            busy_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            src_q            <= src_d;
            last_src_q       <= last_src_d;
            tx_tmr_q         <= tx_tmr_d;
            gap_tmr_q        <= gap_tmr_d;
            vid_pkt_cnt_q    <= vid_pkt_cnt_d;
            err_timeout_q    <= err_timeout_d;
            stat_ack_q       <= stat_ack_d;
            tx_send_enable_q <= (state_d == ST_SEND);
            busy_q           <= (state_d != ST_IDLE);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (enable_i && arb_valid) state_d = ST_SEND;
            ST_SEND: if (tx_done_i || (tx_tmr_q == TMR_LAST)) state_d = ST_GAP;
            ST_GAP:  if (gap_tmr_q == '0) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        src_d         = src_q;
        last_src_d    = last_src_q;
        tx_tmr_d      = tx_tmr_q;
        gap_tmr_d     = gap_tmr_q;
        vid_pkt_cnt_d = vid_pkt_cnt_q;
        err_timeout_d = err_timeout_q;
        stat_ack_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (state_d == ST_SEND) begin
                    src_d      = arb_grant;
                    last_src_d = arb_grant;
                    tx_tmr_d   = '0;
                end
            end
            ST_SEND: begin
                tx_tmr_d = tx_tmr_q + TMR_W'(1);
                // A completion on the timeout cycle still counts as success.
                if (tx_done_i) begin
                    if (src_q == SRC_STAT) stat_ack_d = 1'b1;
                    else vid_pkt_cnt_d = vid_pkt_cnt_q + 16'd1;
                end else if (tx_tmr_q == TMR_LAST) begin
                    err_timeout_d = 1'b1;
                end
                if (state_d == ST_GAP) gap_tmr_d = GAP_LAST;
            end
            ST_GAP: begin
                if (gap_tmr_q != '0) gap_tmr_d = gap_tmr_q - GAP_W'(1);
            end
            default: ;
        endcase
    end

    assign tx_send_enable_o = tx_send_enable_q;
    assign tx_src_sel_o     = src_q;
    assign busy_o           = busy_q;
    assign stat_ack_o       = stat_ack_q;
    assign vid_pkt_cnt_o    = vid_pkt_cnt_q;
    assign err_timeout_o    = err_timeout_q;

endmodule

// File: tb/tb_ethernet_tx_sched.sv
// Directed bench for ethernet_tx_sched: source selection, gap timing,
// timeout handling, enable and reset behaviour.
module tb_ethernet_tx_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [11:0] vid_cnt = '0;
    logic        stat_req = 1'b0;
    logic        tx_done = 1'b0;
    logic        stat_ack;
    logic        tx_send_enable;
    logic        tx_src_sel;
    logic        busy;
    logic [15:0] vid_pkt_cnt;
    logic        err_timeout;

    int total = 0;
    int bad = 0;

    always #20 clk = ~clk;

    ethernet_tx_sched dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .enable_i         (enable),
        .vid_fifo_cnt_i   (vid_cnt),
        .stat_req_i       (stat_req),
        .stat_ack_o       (stat_ack),
        .tx_done_i        (tx_done),
        .tx_send_enable_o (tx_send_enable),
        .tx_src_sel_o     (tx_src_sel),
        .busy_o           (busy),
        .vid_pkt_cnt_o    (vid_pkt_cnt),
        .err_timeout_o    (err_timeout)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = 1'b0; stat_req = 1'b0; tx_done = 1'b0; vid_cnt = '0;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic wait_send(output bit ok);
        int n;
        n = 0;
        while (tx_send_enable !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        ok = (tx_send_enable === 1'b1);
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (tx_send_enable !== 1'b0) begin bad++; $display("FAIL rst_send: got %b want 0", tx_send_enable); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        total++; if (stat_ack !== 1'b0) begin bad++; $display("FAIL rst_ack: got %b want 0", stat_ack); end
        total++; if (vid_pkt_cnt !== 16'd0) begin bad++; $display("FAIL rst_cnt: got %0d want 0", vid_pkt_cnt); end
        total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", err_timeout); end
        total++; if (tx_src_sel !== 1'b0) begin bad++; $display("FAIL rst_sel: got %b want 0", tx_src_sel); end
    endtask

    task automatic test_video();
        enable = 1'b1; vid_cnt = 12'd1359;
        for (int i = 0; i < 6; i++) begin
            step();
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL vid_below_thr: got busy=%b want 0", busy); end
        end
        vid_cnt = 12'd1360;
        step();
        total++; if ({tx_send_enable, tx_src_sel, busy} !== 3'b101) begin bad++; $display("FAIL vid_start: got send/sel/busy=%b want 101", {tx_send_enable, tx_src_sel, busy}); end
        repeat (5) step();
        total++; if (tx_send_enable !== 1'b1) begin bad++; $display("FAIL vid_hold: got %b want 1", tx_send_enable); end
        tx_done = 1'b1; step(); tx_done = 1'b0;
        total++; if ({tx_send_enable, busy, stat_ack} !== 3'b010) begin bad++; $display("FAIL vid_done_state: got send/busy/ack=%b want 010", {tx_send_enable, busy, stat_ack}); end
        total++; if (vid_pkt_cnt !== 16'd1) begin bad++; $display("FAIL vid_cnt1: got %0d want 1", vid_pkt_cnt); end
        for (int i = 2; i <= 24; i++) begin
            step();
            total++; if ({busy, tx_send_enable} !== 2'b10) begin bad++; $display("FAIL vid_gap t+%0d: got busy/send=%b want 10", i, {busy, tx_send_enable}); end
        end
        step();
        total++; if ({busy, tx_send_enable} !== 2'b00) begin bad++; $display("FAIL vid_idle t+25: got busy/send=%b want 00", {busy, tx_send_enable}); end
        step();
        total++; if ({tx_send_enable, tx_src_sel} !== 2'b10) begin bad++; $display("FAIL vid_resend t+26: got send/sel=%b want 10", {tx_send_enable, tx_src_sel}); end
        vid_cnt = '0;
        repeat (3) step();
        total++; if (tx_send_enable !== 1'b1) begin bad++; $display("FAIL vid_fifo_drop: got send=%b want 1", tx_send_enable); end
        tx_done = 1'b1; step(); tx_done = 1'b0;
        total++; if (vid_pkt_cnt !== 16'd2) begin bad++; $display("FAIL vid_cnt2: got %0d want 2", vid_pkt_cnt); end
        repeat (26) step();
        total++; if ({busy, tx_send_enable} !== 2'b00) begin bad++; $display("FAIL vid_no_more: got busy/send=%b want 00", {busy, tx_send_enable}); end
        tx_done = 1'b1; step(); tx_done = 1'b0; step();
        total++; if ({vid_pkt_cnt, busy} !== {16'd2, 1'b0}) begin bad++; $display("FAIL done_in_idle: got cnt=%0d busy=%b want 2 0", vid_pkt_cnt, busy); end
    endtask

    task automatic test_round_robin();
        bit ok;
        logic exp_sel;
        int exp_cnt;
        do_reset();
        enable = 1'b1; vid_cnt = 12'd2000; stat_req = 1'b1;
        exp_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            exp_sel = (k % 2 == 1);
            wait_send(ok);
            total++; if (!ok) begin bad++; $display("FAIL rr_start%0d: got no send want send", k); end
            total++; if (tx_src_sel !== exp_sel) begin bad++; $display("FAIL rr_sel%0d: got %b want %b", k, tx_src_sel, exp_sel); end
            repeat (2) step();
            if (k == 3) begin stat_req = 1'b1; end
            tx_done = 1'b1; step(); tx_done = 1'b0;
            if (!exp_sel) exp_cnt++;
            total++; if (stat_ack !== exp_sel) begin bad++; $display("FAIL rr_ack%0d: got %b want %b", k, stat_ack, exp_sel); end
            total++; if (vid_pkt_cnt !== 16'(exp_cnt)) begin bad++; $display("FAIL rr_cnt%0d: got %0d want %0d", k, vid_pkt_cnt, exp_cnt); end
            step();
            total++; if (stat_ack !== 1'b0) begin bad++; $display("FAIL rr_ack_pulse%0d: got %b want 0", k, stat_ack); end
        end
        stat_req = 1'b0; vid_cnt = '0;
        repeat (26) step();
    endtask

    task automatic test_stat_drop();
        bit ok;
        stat_req = 1'b1;
        wait_send(ok);
        total++; if (!ok || tx_src_sel !== 1'b1) begin bad++; $display("FAIL stat_start: got send=%b sel=%b want 1 1", tx_send_enable, tx_src_sel); end
        step(); stat_req = 1'b0; step();
        tx_done = 1'b1; step(); tx_done = 1'b0;
        total++; if (stat_ack !== 1'b1) begin bad++; $display("FAIL stat_drop_ack: got %b want 1", stat_ack); end
        total++; if (vid_pkt_cnt !== 16'd2) begin bad++; $display("FAIL stat_drop_cnt: got %0d want 2", vid_pkt_cnt); end
        repeat (26) step();
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
        enable = 1'b1; vid_cnt = 12'd1360;
        step();
        repeat (4095) step();
        total++; if ({tx_send_enable, err_timeout} !== 2'b10) begin bad++; $display("FAIL to_before: got send/err=%b want 10", {tx_send_enable, err_timeout}); end
        step();
        total++; if ({tx_send_enable, busy, err_timeout, stat_ack} !== 4'b0110) begin bad++; $display("FAIL to_abort: got send/busy/err/ack=%b want 0110", {tx_send_enable, busy, err_timeout, stat_ack}); end
        total++; if (vid_pkt_cnt !== 16'd0) begin bad++; $display("FAIL to_cnt: got %0d want 0", vid_pkt_cnt); end
        n = 0;
        while (tx_send_enable !== 1'b1 && n < 40) begin step(); n++; end
        total++; if (tx_send_enable !== 1'b1 || n != 25) begin bad++; $display("FAIL to_resume: got send=%b after %0d want 1 after 25", tx_send_enable, n); end
        tx_done = 1'b1; step(); tx_done = 1'b0;
        total++; if ({vid_pkt_cnt, err_timeout} !== {16'd1, 1'b1}) begin bad++; $display("FAIL to_after: got cnt=%0d err=%b want 1 1", vid_pkt_cnt, err_timeout); end
        vid_cnt = '0;
        repeat (26) step();
    endtask

    task automatic test_timeout_tie();
        do_reset();
        enable = 1'b1; vid_cnt = 12'd1360;
        step();
        repeat (4095) step();
        tx_done = 1'b1; step(); tx_done = 1'b0;
        total++; if ({vid_pkt_cnt, err_timeout, tx_send_enable} !== {16'd1, 2'b00}) begin bad++; $display("FAIL tie: got cnt=%0d err=%b send=%b want 1 0 0", vid_pkt_cnt, err_timeout, tx_send_enable); end
        vid_cnt = '0;
        repeat (26) step();
    endtask

    task automatic test_enable_drop();
        bit seen;
        enable = 1'b1; vid_cnt = 12'd1360;
        step();
        total++; if (tx_send_enable !== 1'b1) begin bad++; $display("FAIL en_start: got %b want 1", tx_send_enable); end
        enable = 1'b0;
        repeat (3) step();
        total++; if (tx_send_enable !== 1'b1) begin bad++; $display("FAIL en_hold: got %b want 1", tx_send_enable); end
        tx_done = 1'b1; step(); tx_done = 1'b0;
        total++; if ({vid_pkt_cnt, tx_send_enable} !== {16'd2, 1'b0}) begin bad++; $display("FAIL en_done: got cnt=%0d send=%b want 2 0", vid_pkt_cnt, tx_send_enable); end
        seen = 1'b0;
        repeat (40) begin step(); if (tx_send_enable) seen = 1'b1; end
        total++; if ({seen, busy} !== 2'b00) begin bad++; $display("FAIL en_no_restart: got seen/busy=%b want 00", {seen, busy}); end
    endtask

    task automatic test_reset_mid();
        enable = 1'b1;
        step();
        total++; if (tx_send_enable !== 1'b1) begin bad++; $display("FAIL rmid_start: got %b want 1", tx_send_enable); end
        step();
        rst = 1'b1; step(); rst = 1'b0;
        total++; if ({tx_send_enable, busy, stat_ack, err_timeout, tx_src_sel} !== 5'b0) begin bad++; $display("FAIL rmid_outs: got %b want 00000", {tx_send_enable, busy, stat_ack, err_timeout, tx_src_sel}); end
        total++; if (vid_pkt_cnt !== 16'd0) begin bad++; $display("FAIL rmid_cnt: got %0d want 0", vid_pkt_cnt); end
    endtask

    initial begin
        test_reset();
        test_video();
        test_round_robin();
        test_stat_drop();
        test_timeout();
        test_timeout_tie();
        test_enable_drop();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ethernet_tx_sched.md
# ethernet_tx_sched

Packet scheduler sitting in front of `ethernet_tx`. Decides when a packet may start, which of two sources (video payload FIFO or status/heartbeat generator) feeds it, holds `ethernet_tx`'s send enable for the packet's duration, and enforces the inter-frame gap. It also guards each packet with a completion timeout. It drives the `datain` source mux select and counts completed video packets.

## Interface
Parameters:
- `PAYLOAD_BYTES`, 1360: bytes per video packet; the video source is eligible when the FIFO holds at least this many.
- `FIFO_CNT_W`, 12: width of the video FIFO byte-count input.
- `IFG_CYCLES`, 24: idle clocks between packets (12 bytes at 4-bit/25 MHz).
- `TX_TIMEOUT`, 4096: maximum `clk` cycles in SEND before abort.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: 25 MHz TX clock.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: global permission to start new packets.
- `vid_fifo_cnt` in FIFO_CNT_W: bytes currently in the video FIFO.
- `stat_req` in 1: status packet pending; level, held until `stat_ack`.
- `stat_ack` out 1: one-cycle pulse when a status packet completes.
- `tx_done` in 1: one-cycle pulse from `ethernet_tx` on the last nibble of a packet.
- `tx_send_enable` out 1: to `ethernet_tx`; high for the whole packet.
- `tx_src_sel` out 1: `datain` mux select, 0 = video, 1 = status; stable while `tx_send_enable` = 1.
- `busy` out 1: high in the SEND or GAP state.
- `vid_pkt_cnt` out 16: completed video packets; wraps from 0xFFFF to 0.
- `err_timeout` out 1: sticky; set on abort, cleared only by `rst`.

## Operation
- States: IDLE, SEND, GAP. All outputs are registered.
- Reset values: state IDLE, all outputs 0, `last_src` = 1 (status), timers 0.
- Video eligibility: `vid_rdy` = (`vid_fifo_cnt` >= PAYLOAD_BYTES), using an unsigned compare at FIFO_CNT_W bits.
- IDLE:
  - Transition to SEND occurs only if `enable` = 1 and (`vid_rdy` or `stat_req`).
  - Source choice: if exactly one source is ready, pick it. If both are ready, pick the source that is not `last_src` (round-robin).
  - The chosen source is latched into `src` and `last_src`.
- SEND:
  - `tx_send_enable` = 1 and `tx_src_sel` = `src`; the timer increments every cycle.
  - On `tx_done`, go to GAP:
    - if `src` = status, pulse `stat_ack`;
    - if `src` = video, increment `vid_pkt_cnt`.
  - If the timer reaches TX_TIMEOUT-1 without `tx_done`, go to GAP:
    - set `err_timeout`;
    - issue no `stat_ack` and no counter increment.
  - If `tx_done` and the timeout coincide, `tx_done` wins.
- GAP: `tx_send_enable` = 0; after IFG_CYCLES cycles, go to IDLE.
- Boundary behaviour:
  - `enable` falling during SEND or GAP does not abort; the packet finishes and no new packet starts.
  - `tx_done` outside SEND is ignored.
  - `stat_req` dropping during SEND is ignored; `stat_ack` is still pulsed.
  - `vid_fifo_cnt` dropping during SEND is ignored.
  - `rst` in any state returns to the reset values on the next edge, including mid-packet; `tx_send_enable` drops.

## Timing
- Request seen in IDLE at edge t: `tx_send_enable` and `busy` are high from t+1.
- `tx_done` at t:
  - at t+1: state GAP, `tx_send_enable` = 0, `stat_ack`/`vid_pkt_cnt` update;
  - `stat_ack` is high for exactly cycle t+1.
- GAP occupies cycles t+1 .. t+IFG_CYCLES; IDLE at t+IFG_CYCLES+1; earliest next `tx_send_enable` at t+IFG_CYCLES+2.
- Timer width: $clog2(TX_TIMEOUT); cleared on entry to SEND.
- Gap counter width: $clog2(IFG_CYCLES+1).

## Structure
- Shared package `eth_tx_pkg`: state encodings (IDLE/SEND/GAP), SRC_VID = 0 / SRC_STAT = 1, default PAYLOAD_BYTES/IFG_CYCLES/TX_TIMEOUT. `ethernet_tx` uses the same payload constant.
- One sub-module: `eth_tx_rr_arb`, a 2-way round-robin arbiter (inputs: two requests and `last_src`; outputs: grant and valid). Combinational, instantiated once.
- The FSM, timers and counters live in the top module.

## Test plan
- Video only: `vid_fifo_cnt` = 1360, `enable` = 1 → `tx_send_enable` rises 1 cycle later with `tx_src_sel` = 0; `tx_done` → `vid_pkt_cnt` = 1, next send 26 cycles after `tx_done` if still ready. `vid_fifo_cnt` = 1359 → no send.
- Both sources ready continuously → grants alternate video, status, video, status; `stat_ack` is a 1-cycle pulse after each status `tx_done`.
- Timeout: withhold `tx_done` → abort after 4096 SEND cycles, `err_timeout` = 1 and stays set, `vid_pkt_cnt` unchanged, GAP then normal service resumes.
- `tx_done` on the same cycle as the timeout → counted as success, `err_timeout` stays 0.
- `enable` dropped mid-SEND → packet completes on `tx_done`, then IDLE with no further starts. `rst` mid-SEND → all outputs 0 next cycle.
- Counter wrap: preload via 65536 short packets (TX_TIMEOUT and `tx_done` forced early) → `vid_pkt_cnt` wraps 0xFFFF → 0.
